pwm_dynamic_core: RTL and testbench
===================================

# pwm_dynamic_core

Single-channel 8-bit PWM generator with a runtime-programmable duty cycle. A free-running period counter of 255 clocks is compared against a duty register that is reloaded from `pwm_count` only at period boundaries, so duty changes never produce runt pulses. Sits between a control/register block that supplies `pwm_count` and a pad or driver that consumes `pwm`.

## Interface
- `WIDTH`, 8: resolution in bits; period = 2^WIDTH − 1 clocks.
- `clock`  in  1  rising-edge system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  synchronous active-high hold/restart; while high the generator is parked and the duty register tracks `pwm_count`.
- `pwm_count`  in  WIDTH  requested high time in clocks per period (0 … 2^WIDTH − 1).
- `pwm`  out  1  PWM output, registered.

## Operation
- State: `cnt` (WIDTH bits, range 0 … 2^WIDTH − 2), `duty_q` (WIDTH bits), `pwm` register.
- Reset (`reset_n` low, asynchronous): `cnt` = 0, `duty_q` = 0, `pwm` = 0.
- Hold (`enable` high at a clock edge): `cnt` ← 0, `duty_q` ← `pwm_count`, `pwm` ← 0.
- Run (`enable` low):
  - `pwm` ← (`cnt` < `duty_q`), unsigned compare, using pre-edge values.
  - If `cnt` = 2^WIDTH − 2 (254): `cnt` ← 0 and `duty_q` ← `pwm_count` (period-boundary reload).
  - Else `cnt` ← `cnt` + 1; `duty_q` unchanged.
- `pwm_count` changes mid-period take effect at the next wrap; no effect on the current period.
- Duty = `duty_q` / 255: 0 → constant low; 255 → constant high (no low cycle, since `cnt` never reaches 255); 128 → 128 high / 127 low.
- `enable` asserted mid-period: aborts the period on the next edge; `pwm` low from that edge on.
- `reset_n` asserted at any time overrides `enable` and `pwm_count`.

## Timing
- `pwm` latency: one clock from the compare operands; first run edge after `enable` falls evaluates `cnt` = 0, so `pwm` reflects the new duty one clock after `enable` is sampled low.
- Period exactly 255 clocks in run mode; `pwm` high for exactly `duty_q` consecutive clocks, starting at the first edge of each period.
- New `pwm_count` values are sampled at every hold edge and at every wrap edge; no other sampling points.
- No handshake; `pwm_count` must be stable around the sampling edge (same clock domain).
- Output glitch-free: `pwm` is a flop output only.

## Structure
- Shared package `pwm_pkg`: `PWM_WIDTH` = 8, `PWM_PERIOD` = 2^PWM_WIDTH − 1, and a `pwm_duty_t` logic[PWM_WIDTH−1:0] typedef.
- One natural sub-module, `pwm_period_counter`: wrap counter with synchronous clear, producing `cnt` and a `wrap` strobe; the top holds `duty_q`, the compare and the `pwm` flop.

## Test plan
- Reset: hold `reset_n` low with `enable` = 0, `pwm_count` = 200 → `pwm` = 0, `cnt` = 0; release → first period uses `duty_q` loaded at the first wrap (0 in the first period, so `pwm` stays low for 255 clocks).
- Duty 0: pulse `enable` 1 clock with `pwm_count` = 0, then run 3 periods → `pwm` never high.
- Duty 59: pulse `enable`, `pwm_count` = 59 → each 255-clock period shows exactly 59 high then 196 low clocks; first rise one clock after `enable` sampled low.
- Duty 128 / 191 / 255: same procedure → 128/127, 191/64, and constant high across wrap boundaries.
- Mid-period update: running at 59, change `pwm_count` to 191 at `cnt` = 100 → current period stays 59 high; next period 191 high.
- Enable abort: assert `enable` at `cnt` = 30 with duty 128 → `pwm` low on next edge, `cnt` = 0 held; on release, fresh period starts with latest `pwm_count`.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the dynamic-duty PWM generator.
// Sized for the default 8-bit resolution.
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = (1 << PWM_WIDTH) - 1;

  typedef logic [PWM_WIDTH-1:0] pwm_duty_t;

  // Last counter value of a period; the period spans 0 .. 2^w-2.
  function automatic int unsigned pwm_last_cnt(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter with synchronous clear and wrap strobe.
// Counts 0 .. 2^WIDTH-2, so the period is 2^WIDTH-1 clocks.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(pwm_last_cnt(WIDTH));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_dynamic_core.sv
// Single-channel PWM; duty reloads only at period wrap or while parked,
// so a new duty never truncates or stretches the pulse in flight.
module pwm_dynamic_core
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] pwm_count,
  output logic             pwm
);

  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic             pwm_q;
  logic             pwm_d;

  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (enable),
    .cnt_o   (cnt),
    .wrap_o  (wrap)
  );

  always_comb begin
    duty_d = duty_q;
    if (enable || wrap) begin
      duty_d = pwm_count;
    end
  end

  // Compare uses pre-edge cnt/duty; parked generator drives low.
  assign pwm_d = !enable && (cnt < duty_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_dynamic_core.sv
// Scoreboard bench: driver queues expected pwm per edge,
// monitor pops and compares after each rising edge.
module tb_pwm_dynamic_core;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [7:0] pwm_count;
  logic       pwm;

  typedef struct {
    logic v;
    int   tst;
    int   k;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   tst;
  int   cur;

  pwm_dynamic_core dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .pwm_count (pwm_count),
    .pwm       (pwm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one output per rising edge while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (pwm !== e.v) begin
          bad++;
          $display("FAIL pwm test=%0d k=%0d got=%b exp=%b",
                   e.tst, e.k, pwm, e.v);
        end
      end
    end
  end

  // Called at a negedge: drive inputs, queue result of next edge.
  task automatic drive(input logic en, input logic ev, input int k);
    exp_t e;
    enable    = en;
    pwm_count = cur[7:0];
    e.v = ev;
    e.tst = tst;
    e.k = k;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic hold(input int c);
    cur = c;
    drive(1'b1, 1'b0, -1);
  endtask

  // One full 255-clock period; pwm_count switches to nv at k == at_k.
  task automatic run_period(input int duty, input int at_k, input int nv);
    for (int k = 0; k < 255; k++) begin
      if (k == at_k) cur = nv;
      drive(1'b0, logic'(k < duty), k);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    tst       = 0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    pwm_count = 8'd200;
    cur       = 200;
    repeat (3) @(negedge clock);
    chk("rst_pwm", pwm, 1'b0);

    // First period after reset runs with duty 0, then 200 reloads.
    reset_n = 1'b1;
    run_period(0, -1, 0);
    tst = 1;
    run_period(200, -1, 0);

    tst = 2;
    hold(0);
    repeat (3) run_period(0, -1, 0);

    tst = 3;
    hold(59);
    repeat (2) run_period(59, -1, 0);

    tst = 4;
    hold(128);
    repeat (2) run_period(128, -1, 0);

    tst = 5;
    hold(191);
    repeat (2) run_period(191, -1, 0);

    tst = 6;
    hold(255);
    repeat (2) run_period(255, -1, 0);

    // Mid-period update lands only at the next wrap.
    tst = 7;
    hold(59);
    run_period(59, 100, 191);
    run_period(191, -1, 0);

    // Abort at cnt 30; duty tracks pwm_count while parked.
    tst = 8;
    hold(128);
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1, k);
    hold(128);
    hold(100);
    hold(77);
    run_period(77, -1, 0);

    // Async reset while output is high.
    tst = 9;
    hold(255);
    for (int k = 0; k < 40; k++) drive(1'b0, 1'b1, k);
    drain();
    chk("pre_rst_high", pwm, 1'b1);
    #1 reset_n = 1'b0;
    #1 chk("async_rst", pwm, 1'b0);
    @(posedge clock);
    #1 chk("rst_hold", pwm, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    cur = 255;
    run_period(0, -1, 0);
    drive(1'b0, 1'b1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
